// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect request and the
// valid/ready instruction stream toward decode.
interface instruction_fetch_unit_if #(
    parameter int QDEPTH = 2
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   imem_address;
    logic [31:0]   imem_data;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   instruction;
    logic [31:0]   inst_pc;
    logic [CW-1:0] queue_count;

    modport master (
        output imem_address,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output instruction,
        output inst_pc,
        output queue_count
    );

    modport slave (
        input  imem_address,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  instruction,
        input  inst_pc,
        input  queue_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC, captures the memory word and
// buffers {pc, instruction} pairs in a small circular prefetch queue.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_fetch_unit_if.master bus
);
    localparam int             PW         = $clog2(QDEPTH);
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(QDEPTH);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   pc_mem_r   [QDEPTH];
    logic [31:0]   inst_mem_r [QDEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   head_inst_s;
    logic [31:0]   head_pc_s;

    // Handshake decode and zero-gated head view of the queue.
    always_comb begin
        valid_s     = (count_r != {CW{1'b0}});
        pop_s       = valid_s & bus.inst_ready;
        push_s      = ~bus.redirect & ((count_r < FULL_COUNT) | pop_s);
        head_inst_s = 32'h0000_0000;
        head_pc_s   = 32'h0000_0000;
        if (valid_s) begin
            head_inst_s = inst_mem_r[head_r];
            head_pc_s   = pc_mem_r[head_r];
        end else begin
            head_inst_s = 32'h0000_0000;
            head_pc_s   = 32'h0000_0000;
        end
    end

    // Fetch PC, queue pointers and occupancy; redirect overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (bus.redirect) begin
            // Low address bits are dropped so the target is always word aligned.
            fetch_pc_r <= bus.redirect_pc & 32'hFFFF_FFFC;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                tail_r     <= tail_r + PTR_ONE;
            end else begin
                fetch_pc_r <= fetch_pc_r;
                tail_r     <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; cleared on reset so stale entries are never undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                inst_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]   <= fetch_pc_r;
            inst_mem_r[tail_r] <= bus.imem_data;
        end else begin
            pc_mem_r[tail_r]   <= pc_mem_r[tail_r];
            inst_mem_r[tail_r] <= inst_mem_r[tail_r];
        end
    end

    assign bus.imem_address = fetch_pc_r;
    assign bus.inst_valid   = valid_s;
    assign bus.instruction  = head_inst_s;
    assign bus.inst_pc      = head_pc_s;
    assign bus.queue_count  = count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: cycle table plus hand sequences,
// with a scoreboard of the expected accepted PC stream.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    instruction_fetch_unit_if #(.QDEPTH(2)) bus ();
    instruction_fetch_unit_if #(.QDEPTH(2)) bus_w ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3408_0032;
            32'h0000_0004: return 32'hac08_0000;
            32'h0000_0008: return 32'h8c09_0000;
            32'h0000_00B0: return 32'h0800_0002;
            32'h0000_00C4: return 32'h0c00_0035;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign bus.imem_data   = mem_word(bus.imem_address);
    assign bus_w.imem_data = mem_word(bus_w.imem_address);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  count;
        logic [31:0] addr;
    } obs_t;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        obs_t        exp;
    } vec_t;

    obs_t        main_obs;
    obs_t        w_obs;
    logic [31:0] sb_q[$];
    vec_t        vecs[18];

    assign main_obs = '{bus.inst_valid, bus.inst_pc, bus.instruction,
                        8'(bus.queue_count), bus.imem_address};
    assign w_obs    = '{bus_w.inst_valid, bus_w.inst_pc, bus_w.instruction,
                        8'(bus_w.queue_count), bus_w.imem_address};

    function automatic obs_t mk(input logic v, input logic [31:0] pc,
                                input logic [7:0] cnt, input logic [31:0] addr);
        obs_t o;
        o.valid = v;
        o.pc    = v ? pc : 32'h0;
        o.inst  = v ? mem_word(pc) : 32'h0;
        o.count = cnt;
        o.addr  = addr;
        return o;
    endfunction

    function automatic vec_t mkv(input logic rdy, input logic rd, input logic [31:0] rpc,
                                 input obs_t e);
        vec_t r;
        r.ready = rdy;
        r.redir = rd;
        r.rpc   = rpc;
        r.exp   = e;
        return r;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got v=%0b pc=%h inst=%h cnt=%0d addr=%h, want v=%0b pc=%h inst=%h cnt=%0d addr=%h",
                     name, act.valid, act.pc, act.inst, act.count, act.addr,
                     exp.valid, exp.pc, exp.inst, exp.count, exp.addr);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        for (int k = 0; k < 4; k++) sb_q.push_back((start & 32'hFFFF_FFFC) + 32'(4 * k));
    endtask

    // One clock: drive inputs, score any handshake that the coming edge completes.
    task automatic cycle(input logic ready, input logic redir, input logic [31:0] rpc);
        logic [31:0] exp_pc;
        bus.inst_ready  = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        if (redir) begin
            sb_restart(rpc);
        end else if (bus.inst_valid && ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL handshake: accepted pc=%h, want no acceptance", bus.inst_pc);
            end else begin
                exp_pc = sb_q.pop_front();
                if (bus.inst_pc !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL handshake: got {%h,%h}, want {%h,%h}",
                             bus.inst_pc, bus.instruction, exp_pc, mem_word(exp_pc));
                end
            end
        end
        @(negedge clk);
    endtask

    // Reset asserted on a negedge and released 2 ns later, well before the next posedge.
    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.inst_ready   = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus_w.inst_ready = 1'b0;
        #2;
        check_obs("reset_state", main_obs, mk(1'b0, 32'h0, 8'd0, 32'h0000_0000));
        rst = 1'b0;
        sb_restart(32'h0000_0000);
    endtask

    initial begin
        rst               = 1'b1;
        bus.inst_ready    = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus_w.inst_ready  = 1'b0;
        bus_w.redirect    = 1'b0;
        bus_w.redirect_pc = 32'h0;

        // Backpressure, redirects (aligned, misaligned, while full, back-to-back).
        vecs[0]  = mkv(1'b0, 1'b0, 32'h0,  mk(1'b0, 32'h00, 8'd0, 32'h00));
        vecs[1]  = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'h00, 8'd1, 32'h04));
        vecs[2]  = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'h00, 8'd2, 32'h08));
        vecs[3]  = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'h00, 8'd2, 32'h08));
        vecs[4]  = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'h00, 8'd2, 32'h08));
        vecs[5]  = mkv(1'b1, 1'b0, 32'h0,  mk(1'b1, 32'h00, 8'd2, 32'h08));
        vecs[6]  = mkv(1'b1, 1'b0, 32'h0,  mk(1'b1, 32'h04, 8'd2, 32'h0C));
        vecs[7]  = mkv(1'b1, 1'b1, 32'hB0, mk(1'b1, 32'h08, 8'd2, 32'h10));
        vecs[8]  = mkv(1'b1, 1'b0, 32'h0,  mk(1'b0, 32'h00, 8'd0, 32'hB0));
        vecs[9]  = mkv(1'b1, 1'b0, 32'h0,  mk(1'b1, 32'hB0, 8'd1, 32'hB4));
        vecs[10] = mkv(1'b1, 1'b1, 32'hC6, mk(1'b1, 32'hB4, 8'd1, 32'hB8));
        vecs[11] = mkv(1'b0, 1'b0, 32'h0,  mk(1'b0, 32'h00, 8'd0, 32'hC4));
        vecs[12] = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'hC4, 8'd1, 32'hC8));
        vecs[13] = mkv(1'b1, 1'b1, 32'h00, mk(1'b1, 32'hC4, 8'd2, 32'hCC));
        vecs[14] = mkv(1'b1, 1'b1, 32'h08, mk(1'b0, 32'h00, 8'd0, 32'h00));
        vecs[15] = mkv(1'b1, 1'b0, 32'h0,  mk(1'b0, 32'h00, 8'd0, 32'h08));
        vecs[16] = mkv(1'b1, 1'b0, 32'h0,  mk(1'b1, 32'h08, 8'd1, 32'h0C));
        vecs[17] = mkv(1'b0, 1'b0, 32'h0,  mk(1'b1, 32'h0C, 8'd1, 32'h10));

        // Streaming from reset with decode always ready.
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        check_obs("stream_c1", main_obs, mk(1'b1, 32'h00, 8'd1, 32'h04));
        cycle(1'b1, 1'b0, 32'h0);
        check_obs("stream_c2", main_obs, mk(1'b1, 32'h04, 8'd1, 32'h08));
        cycle(1'b1, 1'b0, 32'h0);
        check_obs("stream_c3", main_obs, mk(1'b1, 32'h08, 8'd1, 32'h0C));
        cycle(1'b1, 1'b0, 32'h0);

        // Table-driven sequence.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            check_obs($sformatf("vec%0d", i), main_obs, vecs[i].exp);
            cycle(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
        end

        // Async reset pulse between edges while the queue is full.
        check_obs("pre_pulse", main_obs, mk(1'b1, 32'h0C, 8'd2, 32'h14));
        rst = 1'b1;
        #1;
        check_obs("async_reset", main_obs, mk(1'b0, 32'h0, 8'd0, 32'h00));
        #1;
        rst = 1'b0;
        sb_restart(32'h0000_0000);
        cycle(1'b1, 1'b0, 32'h0);
        check_obs("restart", main_obs, mk(1'b1, 32'h00, 8'd1, 32'h04));
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        // PC wrap on the second instance.
        do_reset();
        check_obs("wrap_reset", w_obs, mk(1'b0, 32'h0, 8'd0, 32'hFFFF_FFF8));
        bus_w.inst_ready = 1'b1;
        @(negedge clk);
        check_obs("wrap_c1", w_obs, mk(1'b1, 32'hFFFF_FFF8, 8'd1, 32'hFFFF_FFFC));
        @(negedge clk);
        check_obs("wrap_c2", w_obs, mk(1'b1, 32'hFFFF_FFFC, 8'd1, 32'h0000_0000));
        @(negedge clk);
        check_obs("wrap_c3", w_obs, mk(1'b1, 32'h0000_0000, 8'd1, 32'h0000_0004));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
